sad_block_matcher: RTL and testbench
====================================

// Module: sad_block_matcher
// PURPOSE
//   Parametrised, pipelined SAD engine for full-search block matching. Accepts one row of
//   current-block and candidate-block pixels per cycle and accumulates BLK_ROWS rows into a
//   block SAD. Tracks the minimum SAD and its index over NUM_CAND candidates.
//   Sits between the search-window address generator and the motion-vector writer.
// PARAMETERS
//   PIX_W     8    pixel width, unsigned
//   N_PIX     16   pixels per row; power of 2, >=2
//   BLK_ROWS  16   rows per block; >=1
//   NUM_CAND  289  candidates per search (17x17 window); >=1
// PORTS
//   clk        in   1                clock; all logic on rising edge
//   reset      in   1                synchronous, active-low
//   start      in   1                begin new search; clears counters, pipeline and best
//   in_valid   in   1                cur_row/ref_row valid this cycle
//   cur_row    in   N_PIX*PIX_W      current-block row; pixel i = [i*PIX_W +: PIX_W]
//   ref_row    in   N_PIX*PIX_W      candidate-block row, same packing
//   busy       out  1                high in RUN or DRAIN
//   sad_valid  out  1                1-cycle pulse: block SAD complete
//   sad        out  SAD_W            block SAD of the candidate just finished
//   sad_idx    out  CAND_W           index of that candidate, 0..NUM_CAND-1
//   best_valid out  1                1-cycle pulse: search complete
//   best_sad   out  SAD_W            minimum SAD of the search
//   best_idx   out  CAND_W           candidate index of best_sad
// BEHAVIOUR
//   Widths: ROW_W=PIX_W+log2(N_PIX); SAD_W=ROW_W+clog2(BLK_ROWS); CAND_W=clog2(NUM_CAND), min 1.
//   Reset (reset=0 at edge): state=IDLE; all outputs, counters, pipeline valids =0;
//     best_sad = all-ones. Reset overrides start and in_valid.
//   FSM: IDLE -start-> RUN. RUN: a row is accepted when in_valid=1.
//     After row BLK_ROWS-1 of candidate NUM_CAND-1 is accepted -> DRAIN.
//     DRAIN: waits for the last block SAD -> DONE.
//     DONE: one cycle; best_valid=1 -> IDLE.
//   in_valid in IDLE, DRAIN or DONE: ignored. There is no backpressure.
//   start in any state: same-cycle abort. Flush pipeline valids, clear row/cand counters,
//     best_sad=all-ones, best_idx=0, enter RUN. No sad_valid/best_valid for the aborted search.
//     in_valid with start in the same cycle: the row is dropped.
//   Abs diff: |a-b| = (a>=b) ? a-b : b-a, unsigned, PIX_W bits, never overflows.
//   Pipeline: stage 0 registers N_PIX abs diffs. Each adder-tree level is registered
//     (log2(N_PIX) levels, width grows 1 bit per level). Row sum valid L=1+log2(N_PIX)
//     cycles after acceptance (L=5 at defaults). A valid bit travels with each stage.
//   Accumulator: first row of a block loads, later rows add. On row BLK_ROWS-1, the next edge
//     drives sad=total, sad_idx=candidate, sad_valid=1. Block latency = L+1 cycles from
//     last-row acceptance. Back-to-back candidates with no bubbles are supported.
//   Min tracker: updates best on the same edge that sad_valid rises.
//     Condition: new sad < best_sad (strict), so ties keep the lower index.
//     best_valid rises the cycle after the final sad_valid. best_sad/best_idx hold until the
//     next start or reset.
//   Counters wrap: row 0..BLK_ROWS-1; cand 0..NUM_CAND-1 (input side); sad_idx output-side.
//   Gaps in in_valid are legal anywhere; the pipeline carries bubbles.
// STRUCTURE
//   sad_pkg: functions/constants for ROW_W, SAD_W, CAND_W (clog2 helper); FSM state enum
//     {IDLE,RUN,DRAIN,DONE}.
//   Sub-module sad_adder_tree (params N, IN_W): registered binary tree with valid, flush input;
//     latency log2(N). Top holds abs-diff stage, accumulator, counters, FSM and min tracker.
// TESTING
//   Defaults; all cur=0, ref=0, 16 rows x 289 cands contiguous.
//     -> sad=0 each; best_sad=0, best_idx=0 (tie rule).
//   One candidate (NUM_CAND=1): cur=255, ref=0, all 16 rows.
//     -> sad=65280 (max, no overflow); sad_valid 6 cycles after last row.
//   Cand k rows: cur=10, ref=10+(k==37?0:1); others mixed.
//     -> cand 37 sad=0 is best; best_idx=37; best_valid 1 cycle after sad_idx=288.
//   Sign check: cur=0x05, ref=0xFB per pixel.
//     -> per-pixel diff 246; row sum 3936; block sad 62976.
//   Random in_valid gaps (30% idle) vs golden model.
//     -> identical sad sequence to gapless run; no lost rows.
//   start asserted mid-RUN and mid-DRAIN; also reset=0 mid-block.
//     -> no stale sad_valid, restart from idx 0; outputs at reset values.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared width helpers and FSM encoding for the SAD block matcher.
package sad_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int clog2_min1(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int row_w(input int pix_w, input int n_pix);
    return pix_w + clog2(n_pix);
  endfunction

  function automatic int sad_w(input int pix_w, input int n_pix, input int blk_rows);
    return row_w(pix_w, n_pix) + clog2(blk_rows);
  endfunction

  function automatic int cand_w(input int num_cand);
    return clog2_min1(num_cand);
  endfunction

endpackage

// File: rtl/sad_adder_tree.sv
// Registered binary adder tree: N operands of IN_W bits, one register per level,
// a valid bit riding alongside. flush drops everything in flight.
module sad_adder_tree
  import sad_pkg::*;
#(
  parameter int N    = 16,
  parameter int IN_W = 8,
  localparam int LVLS  = clog2(N),
  localparam int OUT_W = IN_W + LVLS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_vld,
  input  logic [N*IN_W-1:0]   in_data,
  output logic                out_vld,
  output logic [OUT_W-1:0]    out_data
);

  logic [LVLS:1] vld_pipe_q;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= in_vld;
      for (int k = 2; k <= LVLS; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
    end
  end

  // Level l holds N>>l partial sums, each one bit wider than the level below.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [(N>>l)-1:0][IN_W+l-1:0] d;
    if (l == 0) begin : g_in
      assign d = in_data;
    end else begin : g_add
      always_ff @(posedge clk) begin
        for (int j = 0; j < (N >> l); j++)
          d[j] <= {1'b0, g_lvl[l-1].d[2*j]} + {1'b0, g_lvl[l-1].d[2*j+1]};
      end
    end
  end

  assign out_vld  = vld_pipe_q[LVLS];
  assign out_data = g_lvl[LVLS].d[0];

endmodule

// File: rtl/sad_block_matcher.sv
// Full-search SAD engine: abs-diff stage, adder tree, block accumulator,
// input/output counters, search FSM and running-minimum tracker.
module sad_block_matcher
  import sad_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int N_PIX    = 16,
  parameter int BLK_ROWS = 16,
  parameter int NUM_CAND = 289,
  localparam int ROW_W  = row_w(PIX_W, N_PIX),
  localparam int SAD_W  = sad_w(PIX_W, N_PIX, BLK_ROWS),
  localparam int CAND_W = cand_w(NUM_CAND)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [N_PIX*PIX_W-1:0] cur_row,
  input  logic [N_PIX*PIX_W-1:0] ref_row,
  output logic                   busy,
  output logic                   sad_valid,
  output logic [SAD_W-1:0]       sad,
  output logic [CAND_W-1:0]      sad_idx,
  output logic                   best_valid,
  output logic [SAD_W-1:0]       best_sad,
  output logic [CAND_W-1:0]      best_idx
);

  localparam int RC_W = clog2_min1(BLK_ROWS);
  localparam logic [RC_W-1:0]   ROW_LAST  = RC_W'(BLK_ROWS - 1);
  localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(NUM_CAND - 1);

  state_e                    state_q, state_d;
  logic [RC_W-1:0]           in_row_q, out_row_q;
  logic [CAND_W-1:0]         in_cand_q, out_cand_q;
  logic [N_PIX-1:0][PIX_W-1:0] absd, diff_q;
  logic                      diff_vld_q;
  logic                      t_vld;
  logic [ROW_W-1:0]          t_sum;
  logic [SAD_W-1:0]          acc_q, blk_sum, sad_q, best_sad_q;
  logic [CAND_W-1:0]         sad_idx_q, best_idx_q;
  logic                      sad_valid_q, best_valid_q;
  logic                      accept, in_last;

  for (genvar i = 0; i < N_PIX; i++) begin : g_absd
    logic [PIX_W-1:0] c, r;
    assign c       = cur_row[i*PIX_W +: PIX_W];
    assign r       = ref_row[i*PIX_W +: PIX_W];
    assign absd[i] = (c >= r) ? c - r : r - c;
  end

  sad_adder_tree #(.N(N_PIX), .IN_W(PIX_W)) u_tree (
    .clk      (clk),
    .reset    (reset),
    .flush    (start),
    .in_vld   (diff_vld_q),
    .in_data  (diff_q),
    .out_vld  (t_vld),
    .out_data (t_sum)
  );

  assign accept  = (state_q == S_RUN) && in_valid && !start;
  assign in_last = accept && (in_row_q == ROW_LAST) && (in_cand_q == CAND_LAST);
  // First row of a block loads; later rows add onto the running total.
  assign blk_sum = (out_row_q == '0) ? SAD_W'(t_sum) : acc_q + SAD_W'(t_sum);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_RUN:   if (in_last) state_d = S_DRAIN;
      S_DRAIN: if (sad_valid_q && sad_idx_q == CAND_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      in_row_q     <= '0;
      in_cand_q    <= '0;
      out_row_q    <= '0;
      out_cand_q   <= '0;
      diff_vld_q   <= 1'b0;
      diff_q       <= '0;
      acc_q        <= '0;
      sad_q        <= '0;
      sad_idx_q    <= '0;
      sad_valid_q  <= 1'b0;
      best_valid_q <= 1'b0;
      best_sad_q   <= '1;
      best_idx_q   <= '0;
    end else if (start) begin
      state_q      <= S_RUN;
      in_row_q     <= '0;
      in_cand_q    <= '0;
      out_row_q    <= '0;
      out_cand_q   <= '0;
      diff_vld_q   <= 1'b0;
      sad_valid_q  <= 1'b0;
      best_valid_q <= 1'b0;
      best_sad_q   <= '1;
      best_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      diff_vld_q   <= accept;
      sad_valid_q  <= t_vld && (out_row_q == ROW_LAST);
      best_valid_q <= (state_d == S_DONE);
      if (accept) begin
        diff_q   <= absd;
        in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + RC_W'(1);
        if (in_row_q == ROW_LAST)
          in_cand_q <= (in_cand_q == CAND_LAST) ? '0 : in_cand_q + CAND_W'(1);
      end
      if (t_vld) begin
        out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + RC_W'(1);
        if (out_row_q == ROW_LAST) begin
          sad_q      <= blk_sum;
          sad_idx_q  <= out_cand_q;
          out_cand_q <= (out_cand_q == CAND_LAST) ? '0 : out_cand_q + CAND_W'(1);
          // Strict compare: on a tie the earlier candidate stays best.
          if (blk_sum < best_sad_q) begin
            best_sad_q <= blk_sum;
            best_idx_q <= out_cand_q;
          end
        end else begin
          acc_q <= blk_sum;
        end
      end
    end
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign sad_valid  = sad_valid_q;
  assign sad        = sad_q;
  assign sad_idx    = sad_idx_q;
  assign best_valid = best_valid_q;
  assign best_sad   = best_sad_q;
  assign best_idx   = best_idx_q;

endmodule

// File: tb/tb_sad_block_matcher.sv
// Bench for sad_block_matcher: scoreboarded random searches on a default instance,
// plus a uniform-pixel vector table on a single-candidate instance.
module tb_sad_block_matcher;

  localparam int PW = 8;
  localparam int NP = 16;
  localparam int BR = 16;
  localparam int NC = 289;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, in_valid, start1, in_valid1;
  logic [NP*PW-1:0] cur_row, ref_row;
  logic busy, sad_valid, best_valid;
  logic [15:0] sad, best_sad;
  logic [8:0]  sad_idx, best_idx;
  logic busy1, sad_valid1, best_valid1;
  logic [15:0] sad1, best_sad1;
  logic [0:0]  sad_idx1, best_idx1;

  sad_block_matcher #(.PIX_W(PW), .N_PIX(NP), .BLK_ROWS(BR), .NUM_CAND(NC)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .cur_row(cur_row), .ref_row(ref_row), .busy(busy),
    .sad_valid(sad_valid), .sad(sad), .sad_idx(sad_idx),
    .best_valid(best_valid), .best_sad(best_sad), .best_idx(best_idx)
  );

  sad_block_matcher #(.PIX_W(PW), .N_PIX(NP), .BLK_ROWS(BR), .NUM_CAND(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1),
    .cur_row(cur_row), .ref_row(ref_row), .busy(busy1),
    .sad_valid(sad_valid1), .sad(sad1), .sad_idx(sad_idx1),
    .best_valid(best_valid1), .best_sad(best_sad1), .best_idx(best_idx1)
  );

  typedef struct { int cv; int rv; int exp; } vec_t;
  vec_t tbl[6];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int exp_sad[$], exp_cyc[$];
  int exp_idx, m_best, m_best_idx, last_sad_cyc;
  bit expect_best, best_seen;
  int sad_pulses, best_pulses;
  int cur_px[NP], ref_px[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard for u0, run once per cycle just after the edge.
  task automatic check_outputs();
    if (sad_valid === 1'b1) begin
      sad_pulses++;
      if (exp_sad.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sad_valid unexpected: got pulse idx %0d, expected none", sad_idx);
      end else begin
        chk("sad", {16'd0, sad}, exp_sad.pop_front());
        chk("sad_idx", {23'd0, sad_idx}, exp_idx);
        chk("sad latency", cyc, exp_cyc.pop_front());
        exp_idx = (exp_idx + 1) % NC;
        last_sad_cyc = cyc;
      end
    end
    if (best_valid === 1'b1) begin
      best_pulses++;
      if (!expect_best) begin
        n_cmp++; n_bad++;
        $display("FAIL best_valid unexpected: got pulse, expected none");
      end else begin
        best_seen = 1'b1;
        chk("best_sad", {16'd0, best_sad}, m_best);
        chk("best_idx", {23'd0, best_idx}, m_best_idx);
        chk("best_valid after final sad", cyc - last_sad_cyc, 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " sad_valid"}, sad_valid, 0);
    chk({tag, " best_valid"}, best_valid, 0);
    chk({tag, " sad"}, sad, 0);
    chk({tag, " sad_idx"}, sad_idx, 0);
    chk({tag, " best_sad"}, best_sad, 32'hFFFF);
    chk({tag, " best_idx"}, best_idx, 0);
  endtask

  // mode 0: zeros; 1: cand 37 exact match, others differ; 2: random pixels
  task automatic set_row(input int mode, input int cand, output int rsum);
    rsum = 0;
    for (int p = 0; p < NP; p++) begin
      case (mode)
        0: begin cur_px[p] = 0; ref_px[p] = 0; end
        1: begin cur_px[p] = 10; ref_px[p] = (cand == 37) ? 10 : 11 + $urandom_range(0, 100); end
        default: begin cur_px[p] = $urandom_range(0, 255); ref_px[p] = $urandom_range(0, 255); end
      endcase
      rsum += (cur_px[p] > ref_px[p]) ? cur_px[p] - ref_px[p] : ref_px[p] - cur_px[p];
      cur_row[p*PW +: PW] = PW'(cur_px[p]);
      ref_row[p*PW +: PW] = PW'(ref_px[p]);
    end
  endtask

  task automatic new_search(input bit with_row);
    int dummy;
    in_valid = with_row;
    if (with_row) set_row(2, 0, dummy);
    start = 1'b1;
    exp_sad.delete(); exp_cyc.delete();
    exp_idx = 0; m_best = 65535; m_best_idx = 0;
    expect_best = 1'b0; best_seen = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic run_search(input int mode, input int gap_pct, input int max_rows, input bit with_row);
    int rs, blk, sent;
    sent = 0;
    new_search(with_row);
    chk("busy in RUN", busy, 1);
    for (int k = 0; k < NC; k++) begin
      blk = 0;
      for (int r = 0; r < BR; r++) begin
        while ($urandom_range(0, 99) < gap_pct) tick();
        set_row(mode, k, rs);
        blk += rs;
        in_valid = 1'b1;
        if (r == BR - 1) begin
          exp_sad.push_back(blk);
          exp_cyc.push_back(cyc + 6);
          if (blk < m_best) begin m_best = blk; m_best_idx = k; end
        end
        tick();
        in_valid = 1'b0;
        sent++;
        if (sent == max_rows) return;
      end
    end
  endtask

  task automatic wait_best();
    expect_best = 1'b1;
    for (int i = 0; i < 40 && !best_seen; i++) tick();
    chk("best_valid seen", best_seen, 1);
    chk("sads outstanding", exp_sad.size(), 0);
    tick();
    chk("busy after done", busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, c0;
    bit found;
    tbl[0] = '{255, 0,   65280};
    tbl[1] = '{5,   251, 62976};
    tbl[2] = '{251, 5,   62976};
    tbl[3] = '{0,   0,   0};
    tbl[4] = '{128, 127, 256};
    tbl[5] = '{1,   3,   512};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; start1 = 1'b0; in_valid1 = 1'b0;
    cur_row = '0; ref_row = '0;
    exp_idx = 0; m_best = 65535; m_best_idx = 0; expect_best = 0; best_seen = 0;
    last_sad_cyc = 0; sad_pulses = 0; best_pulses = 0;
    tick(); tick();
    reset_vals("reset");
    chk("u1 reset best_sad", best_sad1, 32'hFFFF);
    reset = 1'b1;

    // rows offered in IDLE are ignored
    for (int i = 0; i < 20; i++) begin set_row(2, 0, rs); in_valid = 1'b1; tick(); end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("idle rows ignored", sad_pulses, 0);
    chk("idle busy", busy, 0);

    // single-candidate instance: uniform-pixel vector table
    for (int t = 0; t < 6; t++) begin
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int p = 0; p < NP; p++) begin
        cur_row[p*PW +: PW] = PW'(tbl[t].cv);
        ref_row[p*PW +: PW] = PW'(tbl[t].rv);
      end
      c0 = 0;
      for (int r = 0; r < BR; r++) begin
        in_valid1 = 1'b1;
        c0 = cyc;
        tick();
      end
      in_valid1 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (sad_valid1 === 1'b1) begin found = 1'b1; break; end
      end
      chk("u1 sad_valid seen", found, 1);
      chk("u1 sad latency", cyc - c0, 6);
      chk("u1 sad", sad1, tbl[t].exp);
      chk("u1 sad_idx", sad_idx1, 0);
      tick();
      chk("u1 best_valid", best_valid1, 1);
      chk("u1 best_sad", best_sad1, tbl[t].exp);
      chk("u1 best_idx", best_idx1, 0);
    end

    run_search(0, 0, -1, 1'b0);
    wait_best();
    chk("zeros best_sad", best_sad, 0);
    chk("zeros best_idx", best_idx, 0);

    run_search(1, 0, -1, 1'b0);
    wait_best();
    chk("cand37 best_idx", best_idx, 37);
    chk("cand37 best_sad", best_sad, 0);

    // abort mid-RUN; the row presented with start must be dropped
    run_search(2, 0, 100, 1'b0);
    run_search(2, 30, -1, 1'b1);
    wait_best();

    // abort mid-DRAIN: last candidate's result must never appear
    run_search(2, 0, -1, 1'b0);
    repeat (3) tick();
    sad_pulses = 0; best_pulses = 0;
    new_search(1'b0);
    repeat (12) tick();
    chk("drain abort sad pulses", sad_pulses, 0);
    chk("drain abort best pulses", best_pulses, 0);
    chk("drain abort busy", busy, 1);

    // reset in the middle of a block
    run_search(2, 0, 40, 1'b0);
    reset = 1'b0;
    exp_sad.delete(); exp_cyc.delete();
    tick();
    reset_vals("mid reset");
    tick();
    reset = 1'b1;
    sad_pulses = 0;
    repeat (10) tick();
    chk("post reset pulses", sad_pulses, 0);
    reset_vals("post reset");

    run_search(2, 0, -1, 1'b0);
    wait_best();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
